synaptic_integration_scheduler: RTL and testbench
=================================================

# synaptic_integration_scheduler

Sequencer that sweeps the `SynapticIntegrationUnit` (SIU) across all active neurons once per simulation timestep. It drives read addresses into the conductance RAM (gex/gin) and the weight-sum RAM (ExWeightSum/InWeightSum) so that their outputs feed the SIU. It then writes the SIU results (gexOut/ginOut) back to the conductance RAM. It sits between the timestep controller (Start/Done handshake) and the two dual-port RAMs, and is pipelined at one neuron per cycle.

## Interface
- NEURON_WIDTH, 11: neuron address width; max neurons = 2^NEURON_WIDTH.
- Clock  in  1  single clock, all state on rising edge.
- Reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- Start  in  1  one-cycle pulse; begins a sweep; ignored unless in IDLE.
- NeuronCount  in  NEURON_WIDTH+1  number of neurons to sweep; sampled on accepted Start.
- Busy  out  1  high from the cycle after an accepted Start through the Done cycle.
- Done  out  1  one-cycle pulse when the sweep's final write has issued.
- RdEn  out  1  read enable to the conductance RAM and weight-sum RAM read ports.
- RdAddr  out  NEURON_WIDTH  read address, shared by both RAMs.
- CondWrEn  out  1  write enable, conductance RAM write port (data = SIU gexOut/ginOut).
- CondWrAddr  out  NEURON_WIDTH  conductance write address.
- SumClrEn  out  1  write-zero enable, weight-sum RAM write port (see Configuration).
- SumClrAddr  out  NEURON_WIDTH  weight-sum clear address.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. All outputs are registered.
- IDLE: Start=1 with NeuronCount>0 latches the count, clears the index, and moves to RUN.
- IDLE: Start=1 with NeuronCount=0 moves directly to DONE. No RAM access occurs.
- RUN: RdEn=1, RdAddr=index, index++.
  - When the issued index equals count-1, move to DRAIN.
- Write stage: in every cycle after a read issues, CondWrEn=1 and CondWrAddr = the previous RdAddr.
  - RAMs have a 1-cycle read latency, so SIU inputs are valid in the write cycle.
  - Read of n+1 and write of n coincide in the same cycle at different addresses, so the RAMs must be true dual-port.
- DRAIN: RdEn=0. The write for the last neuron issues. Next state is DONE.
- DONE: Done=1 for one cycle, then IDLE.
- Start asserted in any state other than IDLE is ignored and has no latching side effect.
- NeuronCount above 2^NEURON_WIDTH saturates to 2^NEURON_WIDTH.
- Index and counter are NEURON_WIDTH+1 bits, so a full-range sweep does not wrap.
- Reset (any state): returns to IDLE. All outputs become 0, including Busy, Done, all enables and all addresses. Any in-flight write is dropped; it is not completed.

## Timing
- Start accepted at edge 0 with count N≥1:
  - Cycles 1..N: RdEn=1, RdAddr=0..N-1.
  - Cycles 2..N+1: CondWrEn=1, CondWrAddr=0..N-1.
  - Cycle N+2: Done=1.
  - Busy=1 in cycles 1..N+2.
- Total latency Start→Done = N+2 cycles. Throughput is 1 neuron/cycle.
- N=0: Done=1 in cycle 2, Busy=1 in cycles 1..2, no enables.
- Start in the same cycle as Done: ignored, since the FSM is in DONE, not IDLE. The earliest re-accept is the cycle after Done.
- Reset wins over Start in the same cycle.

## Configuration
- SIU_CLEAR_SUMS_EN defined:
  - SumClrEn is asserted together with CondWrEn, with SumClrAddr = CondWrAddr.
  - Each weight-sum entry is zeroed in the same cycle its conductance is written back, so the next timestep accumulates from 0.
- SIU_CLEAR_SUMS_EN undefined:
  - SumClrEn is tied 0 and SumClrAddr is tied 0.
  - Weight sums persist; an external block owns clearing.

## Test plan
- Reset, then Start with NeuronCount=4 → RdAddr 0,1,2,3 in cycles 1–4; CondWrAddr 0..3 in cycles 2–5; Done in cycle 6; Busy high in cycles 1–6. With the RAM model gex[i]=10, ExWeightSum[i]=i, the final gex = 10,11,12,13.
- Start with NeuronCount=0 → no RdEn/CondWrEn; Done in cycle 2.
- Start pulsed again in cycle 3 of a count-4 sweep → no effect: addresses, Done timing and final RAM contents are identical to the first scenario.
- Reset asserted in cycle 3 of a count-8 sweep → next cycle all outputs 0 and state IDLE. Only entries 0–1 are modified. A new Start with count 2 then completes normally with Done in cycle 4.
- Count=2^NEURON_WIDTH (full range) → last RdAddr = all-ones, no wrap to 0, Done at N+2.
- With SIU_CLEAR_SUMS_EN, count=3 → SumClrEn mirrors CondWrEn and ExWeightSum/InWeightSum[0..2]=0 afterwards. Without it, SumClrEn stays 0 and the sums are unchanged.

Source files
------------

// File: rtl/synaptic_integration_scheduler.sv
// synaptic_integration_scheduler
// Sweeps the synaptic integration unit across all active neurons once per
// timestep: one read per cycle into the conductance and weight-sum RAMs and,
// one cycle later, the write-back of the integrated conductance.
//
// Handshake: start is a one-cycle request that is honoured only while the
// FSM is idle; busy stays high from the cycle after an accepted start through
// the done cycle; done is a one-cycle completion pulse. Read and write ports
// are enable-qualified, and an address is meaningful only while its enable is
// high (it is held at 0 otherwise).
//
// Optional feature macro: SIU_CLEAR_SUMS_EN. When defined, each weight-sum
// entry is zeroed in the same cycle its conductance is written back. When
// undefined, the clear port is tied to 0.
module synaptic_integration_scheduler #(
    parameter int NEURON_WIDTH = 11
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NEURON_WIDTH:0]   neuron_count,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [NEURON_WIDTH-1:0] rd_addr,
    output logic                    cond_wr_en,
    output logic [NEURON_WIDTH-1:0] cond_wr_addr,
    output logic                    sum_clr_en,
    output logic [NEURON_WIDTH-1:0] sum_clr_addr,
    output logic [1:0]              state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [NEURON_WIDTH:0] MAX_COUNT = {1'b1, {NEURON_WIDTH{1'b0}}};

    state_t                state;
    logic [NEURON_WIDTH:0] count;
    logic [NEURON_WIDTH:0] idx;
    logic [NEURON_WIDTH:0] sat_count;

    // Clamp the requested sweep length to the addressable neuron range.
    always_comb begin
        sat_count = neuron_count;
        if (neuron_count > MAX_COUNT) begin
            sat_count = MAX_COUNT;
        end
    end

    assign state_dbg = state;

    // Sweep FSM with registered outputs. idx holds the next neuron to read;
    // the write stage simply replays the previous cycle's read one cycle later,
    // matching the one-cycle RAM read latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            idx          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            cond_wr_en   <= 1'b0;
            cond_wr_addr <= '0;
        end else begin
            cond_wr_en   <= rd_en;
            cond_wr_addr <= rd_en ? rd_addr : '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (sat_count == '0) begin
                            state <= DONE;
                        end else begin
                            count   <= sat_count;
                            rd_en   <= 1'b1;
                            rd_addr <= '0;
                            idx     <= {{NEURON_WIDTH{1'b0}}, 1'b1};
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (idx == count) begin
                        // Last read is on the bus this cycle; only its write remains.
                        rd_en   <= 1'b0;
                        rd_addr <= '0;
                        state   <= DRAIN;
                    end else begin
                        rd_en   <= 1'b1;
                        rd_addr <= idx[NEURON_WIDTH-1:0];
                        idx     <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    // An empty sweep enters DONE with done low, so it raises done
                    // here first; a normal sweep arrives with done already high.
                    if (done) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SIU_CLEAR_SUMS_EN
    // Zero each weight-sum entry alongside its conductance write-back.
    always_ff @(posedge clock) begin
        if (reset) begin
            sum_clr_en   <= 1'b0;
            sum_clr_addr <= '0;
        end else begin
            sum_clr_en   <= rd_en;
            sum_clr_addr <= rd_en ? rd_addr : '0;
        end
    end
`else
    assign sum_clr_en   = 1'b0;
    assign sum_clr_addr = '0;
`endif

endmodule

// File: tb/tb_synaptic_integration_scheduler.sv
// Bench for synaptic_integration_scheduler: table of sweeps with per-cycle
// timing expectations, a write-address scoreboard, a RAM/SIU model, and
// hand-written reset and start-collision sequences.
module tb_synaptic_integration_scheduler;

  localparam int W = 11;
  localparam int DEPTH = 1 << W;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W:0]   neuron_count;
  logic         busy;
  logic         done;
  logic         rd_en;
  logic [W-1:0] rd_addr;
  logic         cond_wr_en;
  logic [W-1:0] cond_wr_addr;
  logic         sum_clr_en;
  logic [W-1:0] sum_clr_addr;
  logic [1:0]   state_dbg;

  int n_vec;
  int n_fail;

  logic [W-1:0] exp_q[$];

  // RAM model contents and read registers
  int gex [DEPTH];
  int gin [DEPTH];
  int exs [DEPTH];
  int ins [DEPTH];
  int gex_r, gin_r, exs_r, ins_r;
  logic init_req;

  synaptic_integration_scheduler #(.NEURON_WIDTH(W)) dut (
    .clock        (clk),
    .reset        (reset),
    .start        (start),
    .neuron_count (neuron_count),
    .busy         (busy),
    .done         (done),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .cond_wr_en   (cond_wr_en),
    .cond_wr_addr (cond_wr_addr),
    .sum_clr_en   (sum_clr_en),
    .sum_clr_addr (sum_clr_addr),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM + SIU model ----------------
  // Dual-port RAMs with 1-cycle read latency; the SIU adds the weight sum to
  // the conductance.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < DEPTH; i++) begin
        gex[i] <= 10;
        gin[i] <= 20;
        exs[i] <= i;
        ins[i] <= i + 1;
      end
    end else begin
      if (rd_en) begin
        gex_r <= gex[rd_addr];
        gin_r <= gin[rd_addr];
        exs_r <= exs[rd_addr];
        ins_r <= ins[rd_addr];
      end
      if (cond_wr_en) begin
        gex[cond_wr_addr] <= gex_r + exs_r;
        gin[cond_wr_addr] <= gin_r + ins_r;
      end
      if (sum_clr_en) begin
        exs[sum_clr_addr] <= 0;
        ins[sum_clr_addr] <= 0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int cyc, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic init_ram();
    @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
  endtask

  // Expected RAM contents after one full sweep of n neurons from init values.
  task automatic check_ram(input int n);
    int idxs[5];
    bit clr;
    int i;
`ifdef SIU_CLEAR_SUMS_EN
    clr = 1'b1;
`else
    clr = 1'b0;
`endif
    idxs[0] = 0; idxs[1] = 1; idxs[2] = (n > 0) ? n - 1 : 0;
    idxs[3] = (n < DEPTH) ? n : DEPTH - 1; idxs[4] = DEPTH / 2;
    for (int k = 0; k < 5; k++) begin
      i = idxs[k];
      chk("ram_gex", i, gex[i], (i < n) ? 10 + i : 10);
      chk("ram_gin", i, gin[i], (i < n) ? 21 + i : 20);
      chk("ram_exs", i, exs[i], (clr && i < n) ? 0 : i);
      chk("ram_ins", i, ins[i], (clr && i < n) ? 0 : i + 1);
    end
  endtask

  // Drive one sweep and check every cycle against the expected timeline:
  // reads in cycles 1..n, writes in 2..n+1, done at n+2, busy 1..n+2.
  // A second start (restart_cnt) is pulsed in restart_cycle if nonzero.
  task automatic run_sweep(input int cnt_in, input int n, input int restart_cycle,
                           input int restart_cnt);
    int done_cyc;
    bit e_rd, e_wr;
    logic [W-1:0] got;
    bit clr;
`ifdef SIU_CLEAR_SUMS_EN
    clr = 1'b1;
`else
    clr = 1'b0;
`endif
    done_cyc = n + 2;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(W'(i));
    @(negedge clk);
    start = 1'b1;
    neuron_count = (W+1)'(cnt_in);
    for (int k = 1; k <= n + 4; k++) begin
      @(negedge clk);
      e_rd = (k >= 1) && (k <= n);
      e_wr = (k >= 2) && (k <= n + 1);
      chk("busy", k, int'(busy), int'(k <= done_cyc));
      chk("done", k, int'(done), int'(k == done_cyc));
      chk("rd_en", k, int'(rd_en), int'(e_rd));
      if (e_rd) chk("rd_addr", k, int'(rd_addr), k - 1);
      chk("cond_wr_en", k, int'(cond_wr_en), int'(e_wr));
      if (e_wr) chk("cond_wr_addr", k, int'(cond_wr_addr), k - 2);
      chk("sum_clr_en", k, int'(sum_clr_en), int'(clr && e_wr));
      chk("sum_clr_addr", k, int'(sum_clr_addr), (clr && e_wr) ? k - 2 : 0);
      if (cond_wr_en) begin
        if (exp_q.size() == 0) begin
          chk("sb_extra_write", k, int'(cond_wr_addr), -1);
        end else begin
          got = exp_q.pop_front();
          chk("sb_write_addr", k, int'(cond_wr_addr), int'(got));
        end
      end
      if (k == restart_cycle) begin
        start = 1'b1;
        neuron_count = (W+1)'(restart_cnt);
      end else begin
        start = 1'b0;
      end
    end
    chk("sb_missing_writes", 0, exp_q.size(), 0);
    chk("end_state_idle", 0, int'(state_dbg), 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int cnt_in;
    int n_eff;
    int restart_cycle;
    int restart_cnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    n_vec = 0;
    n_fail = 0;
    reset = 1'b1;
    start = 1'b0;
    neuron_count = '0;
    init_req = 1'b0;

    vecs[0] = '{4,    4,    0, 0};  // basic count-4 sweep
    vecs[1] = '{0,    0,    0, 0};  // empty sweep, done in cycle 2
    vecs[2] = '{4,    4,    3, 7};  // start pulsed mid-sweep, ignored
    vecs[3] = '{1,    1,    0, 0};  // single neuron
    vecs[4] = '{3,    3,    0, 0};  // count 3 (sum clear check)
    vecs[5] = '{2,    2,    4, 3};  // start in the done cycle, ignored
    vecs[6] = '{0,    0,    1, 5};  // start during empty-sweep DONE, ignored
    vecs[7] = '{2048, 2048, 0, 0};  // full range, no wrap

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 0, int'(busy), 0);
    chk("rst_done", 0, int'(done), 0);
    chk("rst_rd_en", 0, int'(rd_en), 0);
    chk("rst_wr_en", 0, int'(cond_wr_en), 0);
    chk("rst_state", 0, int'(state_dbg), 0);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      init_ram();
      run_sweep(vecs[v].cnt_in, vecs[v].n_eff, vecs[v].restart_cycle, vecs[v].restart_cnt);
      check_ram(vecs[v].n_eff);
    end

    // saturation: request above the addressable range sweeps 2^W neurons
    init_ram();
    run_sweep(4095, 2048, 0, 0);
    check_ram(2048);

    // reset in cycle 3 of a count-8 sweep
    init_ram();
    @(negedge clk);
    start = 1'b1;
    neuron_count = 12'd8;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk("mid_rd_addr", k, int'(rd_addr), k - 1);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", 4, int'(busy), 0);
    chk("rst_mid_done", 4, int'(done), 0);
    chk("rst_mid_rd_en", 4, int'(rd_en), 0);
    chk("rst_mid_rd_addr", 4, int'(rd_addr), 0);
    chk("rst_mid_wr_en", 4, int'(cond_wr_en), 0);
    chk("rst_mid_wr_addr", 4, int'(cond_wr_addr), 0);
    chk("rst_mid_clr_en", 4, int'(sum_clr_en), 0);
    chk("rst_mid_state", 4, int'(state_dbg), 0);
    repeat (2) @(negedge clk);
    chk("rst_gex0", 0, gex[0], 10);
    chk("rst_gex1", 1, gex[1], 11);
    chk("rst_gex2", 2, gex[2], 10);
    chk("rst_gin0", 0, gin[0], 21);
    chk("rst_gin1", 1, gin[1], 22);
    chk("rst_gin2", 2, gin[2], 20);
    init_ram();
    run_sweep(2, 2, 0, 0);
    check_ram(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
